// File: rtl/pll_lock_detector.sv
// PLL lock detector: accumulates PFD up/down disagreement per reference period
// and runs a hysteretic lock FSM, with a timeout for a dead reference clock.
//
// state        | meaning
// ST_UNLOCKED  | no lock, waiting for a first good period
// ST_ACQUIRING | counting consecutive good periods toward lock
// ST_LOCKED    | lock declared
// ST_LOSING    | still locked, counting consecutive bad periods
module pll_lock_detector #(
  parameter int ERR_W         = 8,
  parameter int ERR_TOL       = 2,
  parameter int LOCK_CYCLES   = 8,
  parameter int UNLOCK_CYCLES = 4,
  parameter int REF_TIMEOUT   = 1024,
  parameter int TMO_W         = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_reference_clock_digital,
  input  logic             input_up_digital,
  input  logic             input_down_digital,
  output logic             output_lock_digital,
  output logic             output_ref_lost_digital,
  output logic [ERR_W-1:0] output_phase_error_count
);

  localparam int GC_W = $clog2(LOCK_CYCLES + 1);
  localparam int BC_W = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_CYCLES - 1);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(UNLOCK_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_LIM  = ERR_W'(ERR_TOL);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REF_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRING,
    ST_LOCKED,
    ST_LOSING
  } state_t;

  state_t           state;
  logic             ref_d;
  logic             period_valid;
  logic [ERR_W-1:0] err_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GC_W-1:0]  good_cnt;
  logic [BC_W-1:0]  bad_cnt;

  logic rise;
  logic err_bit;
  logic period_good;

  assign rise        = input_reference_clock_digital & ~ref_d;
  assign err_bit     = input_up_digital ^ input_down_digital;
  assign period_good = (err_cnt <= ERR_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= ST_UNLOCKED;
      ref_d                    <= 1'b0;
      period_valid             <= 1'b0;
      err_cnt                  <= '0;
      tmo_cnt                  <= '0;
      good_cnt                 <= '0;
      bad_cnt                  <= '0;
      output_lock_digital      <= 1'b0;
      output_ref_lost_digital  <= 1'b0;
      output_phase_error_count <= '0;
    end else begin
      ref_d <= input_reference_clock_digital;
      if (rise) begin
        // the rise cycle's own error bit belongs to the period it starts
        tmo_cnt                 <= '0;
        err_cnt                 <= {{(ERR_W-1){1'b0}}, err_bit};
        output_ref_lost_digital <= 1'b0;
        period_valid            <= 1'b1;
        if (period_valid) begin
          output_phase_error_count <= err_cnt;
          case (state)
            ST_UNLOCKED: begin
              if (period_good) begin
                state    <= ST_ACQUIRING;
                good_cnt <= GC_ONE;
              end
            end
            ST_ACQUIRING: begin
              if (!period_good) begin
                state    <= ST_UNLOCKED;
                good_cnt <= '0;
              end else if (good_cnt == GC_LAST) begin
                state               <= ST_LOCKED;
                good_cnt            <= '0;
                output_lock_digital <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GC_ONE;
              end
            end
            ST_LOCKED: begin
              if (!period_good) begin
                state   <= ST_LOSING;
                bad_cnt <= BC_ONE;
              end
            end
            ST_LOSING: begin
              if (period_good) begin
                state   <= ST_LOCKED;
                bad_cnt <= '0;
              end else if (bad_cnt == BC_LAST) begin
                state               <= ST_UNLOCKED;
                bad_cnt             <= '0;
                output_lock_digital <= 1'b0;
              end else begin
                bad_cnt <= bad_cnt + BC_ONE;
              end
            end
            default: state <= ST_UNLOCKED;
          endcase
        end
      end else begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_ONE;
        if (err_bit && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_ONE;
        // keeps re-firing while the reference stays dead; harmless and idempotent
        if (tmo_cnt >= TMO_LAST) begin
          state                   <= ST_UNLOCKED;
          output_lock_digital     <= 1'b0;
          output_ref_lost_digital <= 1'b1;
          period_valid            <= 1'b0;
          good_cnt                <= '0;
          bad_cnt                 <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Bench for pll_lock_detector: scenario table with hand-derived end values, a
// reset-in-LOSING sequence, and random traffic checked every cycle against a history model.
module tb_pll_lock_detector;
  localparam int ERR_W         = 8;
  localparam int ERR_TOL       = 2;
  localparam int LOCK_CYCLES   = 8;
  localparam int UNLOCK_CYCLES = 4;
  localparam int REF_TIMEOUT   = 1024;
  localparam int TMO_W         = 11;
  localparam int ERR_MAX       = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ref_clk = 1'b0;
  logic             up = 1'b0;
  logic             dn = 1'b0;
  logic             lock;
  logic             ref_lost;
  logic [ERR_W-1:0] pe;

  pll_lock_detector #(
    .ERR_W(ERR_W), .ERR_TOL(ERR_TOL), .LOCK_CYCLES(LOCK_CYCLES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES), .REF_TIMEOUT(REF_TIMEOUT), .TMO_W(TMO_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_reference_clock_digital(ref_clk),
    .input_up_digital(up),
    .input_down_digital(dn),
    .output_lock_digital(lock),
    .output_ref_lost_digital(ref_lost),
    .output_phase_error_count(pe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: verdict history since the last reset/timeout
  bit m_prev_ref;
  int m_err;
  int m_since;
  bit m_valid;
  bit m_hist[$];
  bit m_lock;
  bit m_lost;
  int m_pe;

  function automatic bit lock_from_history();
    bit locked = 1'b0;
    int run = 0;
    foreach (m_hist[i]) begin
      if (!locked) begin
        run = m_hist[i] ? run + 1 : 0;
        if (run == LOCK_CYCLES) begin locked = 1'b1; run = 0; end
      end else begin
        run = m_hist[i] ? 0 : run + 1;
        if (run == UNLOCK_CYCLES) begin locked = 1'b0; run = 0; end
      end
    end
    return locked;
  endfunction

  task automatic model_step(input bit rst, input bit r, input bit u, input bit d);
    bit rise;
    if (rst) begin
      m_prev_ref = 1'b0; m_err = 0; m_since = 0; m_valid = 1'b0;
      m_hist.delete(); m_lock = 1'b0; m_lost = 1'b0; m_pe = 0;
      return;
    end
    rise = r && !m_prev_ref;
    m_prev_ref = r;
    if (rise) begin
      if (m_valid) begin
        m_pe = (m_err > ERR_MAX) ? ERR_MAX : m_err;
        m_hist.push_back(m_pe <= ERR_TOL);
        m_lock = lock_from_history();
      end
      m_valid = 1'b1; m_lost = 1'b0; m_since = 0;
      m_err = (u != d) ? 1 : 0;
    end else begin
      m_err += (u != d) ? 1 : 0;
      m_since++;
      if (m_since >= REF_TIMEOUT) begin
        m_lost = 1'b1; m_valid = 1'b0; m_lock = 1'b0; m_hist.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit r, input bit u, input bit d);
    reset = rst; ref_clk = r; up = u; dn = d;
    @(posedge clk);
    model_step(rst, r, u, d);
    @(negedge clk);
    check("cycle_lock", 32'(lock), 32'(m_lock));
    check("cycle_ref_lost", 32'(ref_lost), 32'(m_lost));
    check("cycle_phase_err", 32'(pe), 32'(m_pe));
  endtask

  task automatic run_period(input int p, input int ul, input int dl);
    for (int c = 0; c < p; c++) cycle(1'b0, c < p / 2, c < ul, c < dl);
  endtask

  typedef struct {
    bit    rst;
    int    period;   // 0: hold reference low for 'count' cycles
    int    up_len;
    int    dn_len;
    int    count;
    bit    e_lock;
    bit    e_lost;
    int    e_pe;
    string name;
  } row_t;

  row_t rows[$];

  initial begin
    rows.push_back('{1, 20,  0,  0,    8, 0, 0,   0, "clean_8_rises"});
    rows.push_back('{0, 20,  0,  0,    1, 1, 0,   0, "clean_9th_locks"});
    rows.push_back('{0, 20,  5,  0,    4, 1, 0,   5, "bad_x4_losing"});
    rows.push_back('{0, 20,  0,  0,    1, 0, 0,   5, "bad_4th_unlocks"});
    rows.push_back('{0, 20,  0,  0,    8, 1, 0,   0, "relock"});
    rows.push_back('{0, 20,  4,  0,    3, 1, 0,   4, "alt_bad_a"});
    rows.push_back('{0, 20,  3,  1,    1, 1, 0,   4, "alt_tol_good_a"});
    rows.push_back('{0, 20,  4,  0,    3, 1, 0,   4, "alt_bad_b"});
    rows.push_back('{0, 20,  3,  1,    1, 1, 0,   4, "alt_tol_good_b"});
    rows.push_back('{0, 20,  0,  0,    1, 1, 0,   2, "alt_recovered"});
    rows.push_back('{1, 20,  0,  0,    5, 0, 0,   0, "acq_gc4"});
    rows.push_back('{0, 20,  3,  0,    1, 0, 0,   0, "acq_gc5_err3"});
    rows.push_back('{0, 20,  0,  0,    1, 0, 0,   3, "acq_err3_unlocks"});
    rows.push_back('{0, 20,  0,  0,    7, 0, 0,   0, "reacq_7_good"});
    rows.push_back('{0, 20,  0,  0,    1, 1, 0,   0, "reacq_8th_locks"});
    rows.push_back('{1, 20, 10, 10,    8, 0, 0,   0, "both_high_8"});
    rows.push_back('{0, 20, 10, 10,    1, 1, 0,   0, "both_high_locks"});
    rows.push_back('{0, 400, 300, 0,   2, 1, 0, 255, "err_saturates"});
    rows.push_back('{0,  0,  0,  0,  624, 1, 0, 255, "tmo_one_short"});
    rows.push_back('{0,  0,  0,  0,    1, 0, 1, 255, "tmo_fires"});
    rows.push_back('{0, 20,  0,  0,    1, 0, 0, 255, "ref_back_unevaluated"});
    rows.push_back('{0, 20,  0,  0,    8, 1, 0,   0, "relock_after_tmo"});
    rows.push_back('{1, 20,  0,  0,    2, 0, 0,   0, "race_setup"});
    rows.push_back('{0,  0,  0,  0, 1004, 0, 0,   0, "race_hold"});
    rows.push_back('{0, 20,  0,  0,    1, 0, 0,   0, "race_rise_wins"});
    rows.push_back('{0, 20,  0,  0,    6, 1, 0,   0, "race_rise_evaluated"});

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_lock", 32'(lock), 32'd0);
    check("reset_ref_lost", 32'(ref_lost), 32'd0);
    check("reset_phase_err", 32'(pe), 32'd0);

    foreach (rows[i]) begin
      if (rows[i].rst) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (rows[i].period == 0) begin
        repeat (rows[i].count) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        repeat (rows[i].count) run_period(rows[i].period, rows[i].up_len, rows[i].dn_len);
      end
      check({rows[i].name, "_lock"}, 32'(lock), 32'(rows[i].e_lock));
      check({rows[i].name, "_ref_lost"}, 32'(ref_lost), 32'(rows[i].e_lost));
      check({rows[i].name, "_phase_err"}, 32'(pe), 32'(rows[i].e_pe));
    end

    // drive into LOSING, then reset on a rising-reference cycle with an error bit
    run_period(20, 5, 0);
    run_period(20, 5, 0);
    check("losing_lock_held", 32'(lock), 32'd1);
    check("losing_phase_err", 32'(pe), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_in_losing_lock", 32'(lock), 32'd0);
    check("rst_in_losing_ref_lost", 32'(ref_lost), 32'd0);
    check("rst_in_losing_phase_err", 32'(pe), 32'd0);
    repeat (9) run_period(20, 0, 0);
    check("post_rst_relock", 32'(lock), 32'd1);

    for (int n = 0; n < 400; n++) begin
      int sel;
      int p;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end else if (sel < 5) begin
        int len;
        len = $urandom_range(900, 1100);
        for (int c = 0; c < len; c++)
          cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (sel < 15) begin
        p = $urandom_range(2, 40);
        for (int c = 0; c < p; c++)
          cycle(1'b0, c < p / 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        p = $urandom_range(2, 40);
        run_period(p, $urandom_range(0, 4), $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_detector.md
Name: pll_lock_detector

Overview:
- Monitors the phase-frequency detector's up/down pulses against the reference clock and declares PLL lock or loss of lock.
- Sits downstream of the PFD inside the PLL top, in parallel with the charge pump, on the same simulator clock.
- Accumulates phase-error width per reference period and runs a hysteretic lock state machine.
- Flags a dead reference clock via a timeout.

Parameters:
ERR_W, 8, width of per-period phase-error counter (saturating)
ERR_TOL, 2, maximum error clk-cycles per reference period still counted "good"
LOCK_CYCLES, 8, consecutive good periods needed to declare lock (>=2)
UNLOCK_CYCLES, 4, consecutive bad periods needed to drop lock (>=2)
REF_TIMEOUT, 1024, clk cycles without a reference rising edge before ref is declared lost
TMO_W, 11, width of timeout counter (must hold REF_TIMEOUT)

Ports:
clk  input  1  simulator/event clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
input_reference_clock_digital  input  1  reference clock, sampled on clk
input_up_digital  input  1  PFD up pulse
input_down_digital  input  1  PFD down pulse
output_lock_digital  output  1  high while PLL declared locked
output_ref_lost_digital  output  1  high after reference timeout
output_phase_error_count  output  ERR_W  error count of last completed reference period

Behaviour:
- Reset: all outputs 0; state UNLOCKED; all counters 0; period_valid=0; ref_d=0.
- Edge detect: ref_d registers the reference each clk; rise = ref & ~ref_d.
- Error bit per clk: up XOR down. Both high or both low counts as no error.
- err_cnt increments on error-bit cycles and saturates at 2^ERR_W-1.
- On a rise cycle:
  - Evaluate the err_cnt accumulated before this cycle.
  - Then load err_cnt with the current cycle's error bit (1 or 0).
- Evaluation:
  - Occurs only if period_valid=1.
  - The first rise after reset or timeout sets period_valid=1 and is not evaluated.
  - Good period: err_cnt <= ERR_TOL. Bad period: err_cnt > ERR_TOL.
  - output_phase_error_count <= err_cnt on every evaluated rise, registered (1 clk after rise).
- States (good_cnt/bad_cnt update only on evaluated rises):
  - UNLOCKED: good -> ACQUIRING, good_cnt=1. Bad -> stay.
  - ACQUIRING: good -> good_cnt+1; if that reaches LOCK_CYCLES -> LOCKED, good_cnt=0. Bad -> UNLOCKED, good_cnt=0.
  - LOCKED: good -> stay. Bad -> LOSING, bad_cnt=1.
  - LOSING: bad -> bad_cnt+1; if that reaches UNLOCK_CYCLES -> UNLOCKED, bad_cnt=0. Good -> LOCKED, bad_cnt=0.
- output_lock_digital is registered, =1 in LOCKED or LOSING.
  - Asserts 1 clk after the rise that evaluates the LOCK_CYCLES-th consecutive good period.
  - Deasserts 1 clk after the rise that evaluates the UNLOCK_CYCLES-th consecutive bad period.
- Timeout:
  - tmo_cnt clears on rise, else increments, saturating.
  - When tmo_cnt reaches REF_TIMEOUT-1 without a rise:
    - Next clk: state=UNLOCKED, lock=0, ref_lost=1, period_valid=0, good_cnt=bad_cnt=0.
  - ref_lost clears 1 clk after the next rise; that rise is not evaluated.
- Rise and timeout on the same cycle: the rise wins, and tmo_cnt clears.
- Reset mid-operation: returns to reset values next clk regardless of state or pending rise.
- No combinational input-to-output paths.

Test Plan:
- Defaults. Reference period 20 clk, up/down never differ, 9 rises -> lock rises 1 clk after the 9th rise (8 evaluated good periods); error count 0.
- After lock, up high alone 5 clk per period for 4 periods -> state goes to LOSING, lock deasserts 1 clk after the 4th bad rise; error count reads 5.
- Alternate 3 bad then 1 good period while locked -> lock stays 1 throughout (LOSING->LOCKED each time).
- While ACQUIRING at good_cnt=5, inject a period with error=3 -> UNLOCKED; then 8 more good periods are needed before lock.
- Up and down both high 10 clk per period -> counts as 0 error; lock achieved as in scenario 1.
- Locked, then hold reference low 1024 clk -> ref_lost=1 and lock=0. Resume the reference: ref_lost=0 after the first rise, and lock returns after 9 rises.
- Error of 300 clk in a 400-clk period -> error count saturates at 255.
- Assert reset while in LOSING -> all outputs 0 on the next clk.
